// File: rtl/tile_tcdm_banked_mem.sv
// -----------------------------------------------------------------------------
// tile_tcdm_banked_mem
//   Word-interleaved, multi-port banked TCDM model for tile-level simulation.
//   N_PORTS masters share N_MEM_BANKS single-port banks. Each bank has its
//   own round-robin arbiter, so masters hitting different banks are all
//   granted in the same cycle. Read data comes back one cycle after the grant.
//   Denied requests are summed into a saturating conflict counter.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_i   [P]       per-port request (held by the master until granted)
//   gnt_o   [P]       per-port grant, combinational, same cycle as req_i
//   addr_i  [P*AW]    per-port byte address
//   we_i    [P]       1 = write, 0 = read
//   be_i    [P*DW/8]  byte enables, used by writes only
//   wdata_i [P*DW]    write data
//   rvalid_o[P]       response valid, one cycle after each grant
//   rdata_o [P*DW]    read data (zero for write responses)
//   conflict_cnt_o    total denied requests, saturating
// -----------------------------------------------------------------------------
module tile_tcdm_banked_mem #(
    parameter int N_PORTS      = 4,
    parameter int N_MEM_BANKS  = 32,
    parameter int N_WORDS_BANK = 8192,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_PORTS-1:0]          req_i,
    output logic [N_PORTS-1:0]          gnt_o,
    input  logic [N_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [N_PORTS-1:0]          we_i,
    input  logic [N_PORTS*DATA_W/8-1:0] be_i,
    input  logic [N_PORTS*DATA_W-1:0]   wdata_i,
    output logic [N_PORTS-1:0]          rvalid_o,
    output logic [N_PORTS*DATA_W-1:0]   rdata_o,
    output logic [CNT_W-1:0]            conflict_cnt_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int BB_W  = $clog2(N_MEM_BANKS);
    localparam int ROW_W = (N_WORDS_BANK > 1) ? $clog2(N_WORDS_BANK) : 1;
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW1   = CNT_W + 1;

    logic [BB_W-1:0]   bank_idx [N_PORTS];
    logic [ROW_W-1:0]  row_idx  [N_PORTS];
    logic [N_PORTS-1:0] gnt;

    logic [PTR_W-1:0]  rr_q [N_MEM_BANKS];
    logic [PTR_W-1:0]  rr_d [N_MEM_BANKS];
    logic [N_PORTS-1:0] rvalid_q, rvalid_d;
    logic [N_PORTS*DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] mem_q [N_MEM_BANKS][N_WORDS_BANK];

    // Byte offset and bits above the memory size are ignored on purpose,
    // which makes addresses wrap modulo the total memory size.
    logic addr_unused;
    assign addr_unused = ^addr_i;

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            bank_idx[p] = addr_i[p*ADDR_W + OFS +: BB_W];
            row_idx[p]  = addr_i[p*ADDR_W + OFS + BB_W +: ROW_W];
        end
    end

    // Per-bank round-robin: scan ports starting at rr_q[b]; the first
    // requester targeting bank b wins and the pointer moves past it.
    always_comb begin
        int   p_sel;
        logic found;
        gnt   = '0;
        p_sel = 0;
        found = 1'b0;
        for (int b = 0; b < N_MEM_BANKS; b++) begin
            rr_d[b] = rr_q[b];
            found   = 1'b0;
            for (int k = 0; k < N_PORTS; k++) begin
                p_sel = (int'(rr_q[b]) + k) % N_PORTS;
                if (!found && req_i[p_sel] && (int'(bank_idx[p_sel]) == b)) begin
                    found        = 1'b1;
                    gnt[p_sel]   = 1'b1;
                    rr_d[b]      = PTR_W'((p_sel + 1) % N_PORTS);
                end
            end
        end
    end

    // Reads sample the array before this cycle's writes land; a same-bank
    // write in the same cycle cannot exist because only one port wins a bank.
    always_comb begin
        rvalid_d = gnt;
        rdata_d  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (gnt[p] && !we_i[p]) begin
                rdata_d[p*DATA_W +: DATA_W] = mem_q[bank_idx[p]][row_idx[p]];
            end
        end
    end

    always_comb begin
        logic [CW1-1:0] n_denied;
        logic [CW1-1:0] cnt_sum;
        n_denied = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            n_denied = n_denied + CW1'(req_i[p] & ~gnt[p]);
        end
        cnt_sum = {1'b0, cnt_q} + n_denied;
        cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < N_MEM_BANKS; b++) begin
                rr_q[b] <= '0;
            end
            rvalid_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            for (int b = 0; b < N_MEM_BANKS; b++) begin
                rr_q[b] <= rr_d[b];
            end
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is deliberately not reset; benches preload it directly.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (gnt[p] && we_i[p]) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (be_i[p*BYTES + i]) begin
                        mem_q[bank_idx[p]][row_idx[p]][i*8 +: 8] <= wdata_i[p*DATA_W + i*8 +: 8];
                    end
                end
            end
        end
    end

    assign gnt_o          = gnt;
    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_tile_tcdm_banked_mem.sv
module tb_tile_tcdm_banked_mem;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [3:0]     req_i, we_i, gnt_o, rvalid_o;
    logic [127:0]   addr_i, wdata_i, rdata_o;
    logic [15:0]    be_i;
    logic [31:0]    conflict_cnt_o;

    always #5 clk_i = ~clk_i;

    tile_tcdm_banked_mem dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .wdata_i        (wdata_i),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   we;
        logic [127:0] addr;
        logic [127:0] wdata;
        logic [15:0]  be;
        logic [3:0]   exp_gnt;
        logic [31:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [3:0]   vld;
        logic [127:0] data;
    } rsp_t;

    rsp_t        sb[$];
    vec_t        tab_a[$];
    vec_t        tab_b[$];
    logic [31:0] mdl [int];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt_prev = '0;

    // Total size with defaults is 32 banks * 8192 words * 4 bytes = 1 MiB.
    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FFFF);
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] we,
                                input logic [127:0] addr, input logic [127:0] wdata,
                                input logic [15:0] be, input logic [3:0] g,
                                input logic [31:0] c);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.be = be; v.exp_gnt = g; v.exp_cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        int b, r;
        b = int'((a >> 2) & 32'd31);
        r = int'((a >> 7) & 32'd8191);
        dut.mem_q[b][r] = v;
        mdl[widx(a)] = v;
    endtask

    task automatic check_rsp();
        rsp_t e;
        if (sb.size() > 0) e = sb.pop_front();
        else begin e.vld = '0; e.data = '0; end
        check("rvalid", {124'd0, rvalid_o}, {124'd0, e.vld});
        for (int p = 0; p < 4; p++) begin
            if (e.vld[p]) check($sformatf("rdata_p%0d", p), {96'd0, rdata_o[p*32 +: 32]},
                                {96'd0, e.data[p*32 +: 32]});
        end
    endtask

    task automatic drive_idle();
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    endtask

    task automatic apply(input vec_t v);
        rsp_t        e;
        logic [31:0] w;
        int          k;
        @(negedge clk_i);
        check_rsp();
        check("conflict_cnt", {96'd0, conflict_cnt_o}, {96'd0, exp_cnt_prev});
        req_i = v.req; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; be_i = v.be;
        #1;
        check("gnt", {124'd0, gnt_o}, {124'd0, v.exp_gnt});
        e.vld  = v.exp_gnt;
        e.data = '0;
        for (int p = 0; p < 4; p++) begin
            k = widx(v.addr[p*32 +: 32]);
            if (v.exp_gnt[p] && !v.we[p]) e.data[p*32 +: 32] = mdl.exists(k) ? mdl[k] : 32'h0;
        end
        for (int p = 0; p < 4; p++) begin
            k = widx(v.addr[p*32 +: 32]);
            if (v.exp_gnt[p] && v.we[p]) begin
                w = mdl.exists(k) ? mdl[k] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (v.be[p*4 + i]) w[i*8 +: 8] = v.wdata[p*32 + i*8 +: 8];
                mdl[k] = w;
            end
        end
        sb.push_back(e);
        exp_cnt_prev = v.exp_cnt;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive_idle();
        preload(32'h40,  32'h11223344);
        preload(32'h0,   32'hA0A0A0A0);
        preload(32'h4,   32'h04040404);
        preload(32'h8,   32'h08080808);
        preload(32'hC,   32'h0C0C0C0C);
        preload(32'h80,  32'h80808080);
        preload(32'h84,  32'h84848484);
        preload(32'h180, 32'h18018018);

        //                req     we      addr {p3,p2,p1,p0}                         wdata {p3,p2,p1,p0}                                     be        gnt     cnt
        tab_a.push_back(mk(4'h1, 4'h1, {96'h0, 32'h100},                         {96'h0, 32'hDEADBEEF},                                  16'h000F, 4'h1, 32'd0));
        tab_a.push_back(mk(4'h1, 4'h0, {96'h0, 32'h100},                         128'h0,                                                 16'h0000, 4'h1, 32'd0));
        tab_a.push_back(mk(4'h1, 4'h1, {96'h0, 32'h40},                          {96'h0, 32'hAABBCCDD},                                  16'h0005, 4'h1, 32'd0));
        tab_a.push_back(mk(4'h1, 4'h0, {96'h0, 32'h40},                          128'h0,                                                 16'h0000, 4'h1, 32'd0));
        tab_a.push_back(mk(4'hF, 4'h0, {32'hC, 32'h8, 32'h4, 32'h0},             128'h0,                                                 16'h0000, 4'hF, 32'd0));
        tab_a.push_back(mk(4'h2, 4'h2, {32'h0, 32'h0, 32'h100000, 32'h0},        {32'h0, 32'h0, 32'hCAFEF00D, 32'h0},                    16'h00F0, 4'h2, 32'd0));
        tab_a.push_back(mk(4'h4, 4'h0, {32'h0, 32'h0, 32'h0, 32'h0},             128'h0,                                                 16'h0000, 4'h4, 32'd0));
        tab_a.push_back(mk(4'hB, 4'h2, {32'h84, 32'h0, 32'h8, 32'h4},            {32'h0, 32'h0, 32'h55000000, 32'h0},                    16'h0080, 4'hA, 32'd1));
        tab_a.push_back(mk(4'h3, 4'h0, {32'h0, 32'h0, 32'h8, 32'h4},             128'h0,                                                 16'h0000, 4'h3, 32'd1));
        tab_a.push_back(mk(4'h0, 4'h0, 128'h0,                                   128'h0,                                                 16'h0000, 4'h0, 32'd1));

        tab_b.push_back(mk(4'hF, 4'h0, {32'h180, 32'h100, 32'h80, 32'h0},        128'h0,                                                 16'h0000, 4'h1, 32'd3));
        tab_b.push_back(mk(4'hE, 4'h0, {32'h180, 32'h100, 32'h80, 32'h0},        128'h0,                                                 16'h0000, 4'h2, 32'd5));
        tab_b.push_back(mk(4'hC, 4'h0, {32'h180, 32'h100, 32'h80, 32'h0},        128'h0,                                                 16'h0000, 4'h4, 32'd6));
        tab_b.push_back(mk(4'h8, 4'h0, {32'h180, 32'h100, 32'h80, 32'h0},        128'h0,                                                 16'h0000, 4'h8, 32'd6));
        tab_b.push_back(mk(4'h0, 4'h0, 128'h0,                                   128'h0,                                                 16'h0000, 4'h0, 32'd6));

        repeat (2) @(negedge clk_i);
        check("reset_gnt",    {124'd0, gnt_o},          128'd0);
        check("reset_rvalid", {124'd0, rvalid_o},       128'd0);
        check("reset_rdata",  rdata_o,                  128'd0);
        check("reset_cnt",    {96'd0, conflict_cnt_o},  128'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < tab_a.size(); i++) apply(tab_a[i]);

        // Reset one cycle after a grant: the pending response must vanish.
        @(negedge clk_i);
        check_rsp();
        check("conflict_cnt", {96'd0, conflict_cnt_o}, {96'd0, exp_cnt_prev});
        req_i  = 4'h3;
        we_i   = 4'h0;
        addr_i = {32'h0, 32'h0, 32'h80, 32'h0};
        #1;
        check("gnt_pre_reset", {124'd0, gnt_o}, 128'h1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        drive_idle();
        #1;
        check("rst_rvalid", {124'd0, rvalid_o},      128'd0);
        check("rst_rdata",  rdata_o,                 128'd0);
        check("rst_cnt",    {96'd0, conflict_cnt_o}, 128'd0);
        repeat (2) @(negedge clk_i);
        check("rst_hold_rvalid", {124'd0, rvalid_o}, 128'd0);
        rst_ni = 1'b1;
        sb.delete();
        exp_cnt_prev = '0;

        for (int i = 0; i < tab_b.size(); i++) apply(tab_b[i]);

        @(negedge clk_i);
        check_rsp();
        check("conflict_cnt", {96'd0, conflict_cnt_o}, {96'd0, exp_cnt_prev});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
